// File: rtl/vga_pattern_gen.sv
// Multi-mode VGA test-pattern generator: turns raster coordinates into registered colour,
// with frame-synchronous mode switching, a frame counter and a horizontal scroll offset.
module vga_pattern_gen #(
  parameter int COLOR_BITS  = 1,
  parameter int GRID_LOG2   = 3,
  parameter int CHECK_LOG2  = 4,
  parameter int BAR_WIDTH   = 80,
  parameter int SCROLL_STEP = 1,
  parameter int VSYNC_POL   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [10:0]           hpos,
  input  logic [10:0]           vpos,
  input  logic                  video_active,
  input  logic                  vsync,
  input  logic [2:0]            mode_sel,
  input  logic                  mode_load,
  output logic [COLOR_BITS-1:0] red,
  output logic [COLOR_BITS-1:0] green,
  output logic [COLOR_BITS-1:0] blue,
  output logic [2:0]            mode_cur,
  output logic [7:0]            frame_cnt
);

  localparam logic        VS_ACTIVE  = (VSYNC_POL != 0) ? 1'b1 : 1'b0;
  localparam logic [10:0] BAR_LAST   = 11'(BAR_WIDTH - 1);
  localparam logic [10:0] SCROLL_INC = 11'(SCROLL_STEP);

  function automatic logic [COLOR_BITS-1:0] fill(input logic b);
    fill = {COLOR_BITS{b}};
  endfunction

  logic        prev_vsync_r;
  logic [2:0]  mode_pend_r;
  logic [10:0] scroll_off_r;
  logic [10:0] bar_px_r;
  logic [2:0]  bar_idx_r;

  logic        frame_edge_s;
  logic [10:0] cur_px_s;
  logic [2:0]  cur_idx_s;
  logic [10:0] nxt_px_s;
  logic [2:0]  nxt_idx_s;
  logic [10:0] sx_s;
  logic        grid_h_s;
  logic        grid_v_s;
  logic        unused_s;
  logic [COLOR_BITS-1:0] red_s;
  logic [COLOR_BITS-1:0] green_s;
  logic [COLOR_BITS-1:0] blue_s;

  assign frame_edge_s = (vsync == VS_ACTIVE) && (prev_vsync_r != VS_ACTIVE);
  assign sx_s         = hpos + scroll_off_r;
  assign grid_h_s     = (hpos[GRID_LOG2-1:0] == {GRID_LOG2{1'b0}});
  assign grid_v_s     = (vpos[GRID_LOG2-1:0] == {GRID_LOG2{1'b0}});
  assign unused_s     = ^vpos;

  // Bar position for the current pixel and the state handed to the next pixel.
  always_comb begin
    cur_px_s  = bar_px_r;
    cur_idx_s = bar_idx_r;
    nxt_px_s  = 11'd0;
    nxt_idx_s = 3'd0;
    if (hpos == 11'd0 && video_active) begin
      cur_px_s  = 11'd0;
      cur_idx_s = 3'd0;
    end else begin
      cur_px_s  = bar_px_r;
      cur_idx_s = bar_idx_r;
    end
    if (cur_px_s == BAR_LAST) begin
      nxt_px_s  = 11'd0;
      nxt_idx_s = (cur_idx_s == 3'd7) ? 3'd7 : cur_idx_s + 3'd1;
    end else begin
      nxt_px_s  = cur_px_s + 11'd1;
      nxt_idx_s = cur_idx_s;
    end
  end

  // Colour selection for the current pixel, forced to black outside the visible area.
  always_comb begin
    red_s   = {COLOR_BITS{1'b0}};
    green_s = {COLOR_BITS{1'b0}};
    blue_s  = {COLOR_BITS{1'b0}};
    if (!video_active) begin
      red_s   = {COLOR_BITS{1'b0}};
      green_s = {COLOR_BITS{1'b0}};
      blue_s  = {COLOR_BITS{1'b0}};
    end else begin
      case (mode_cur)
        3'd0: begin
          red_s   = fill(grid_h_s | grid_v_s);
          green_s = fill(vpos[4]);
          blue_s  = fill(hpos[4]);
        end
        3'd1: begin
          red_s   = fill(hpos[CHECK_LOG2] ^ vpos[CHECK_LOG2]);
          green_s = fill(hpos[CHECK_LOG2] ^ vpos[CHECK_LOG2]);
          blue_s  = fill(hpos[CHECK_LOG2] ^ vpos[CHECK_LOG2]);
        end
        3'd2: begin
          red_s   = fill(~cur_idx_s[1]);
          green_s = fill(~cur_idx_s[2]);
          blue_s  = fill(~cur_idx_s[0]);
        end
        3'd3: begin
          red_s   = hpos[4 +: COLOR_BITS];
          green_s = vpos[4 +: COLOR_BITS];
          blue_s  = frame_cnt[7 -: COLOR_BITS];
        end
        3'd4: begin
          red_s   = fill(sx_s[GRID_LOG2-1:0] == {GRID_LOG2{1'b0}});
          green_s = {COLOR_BITS{1'b0}};
          blue_s  = fill(grid_v_s);
        end
        default: begin
          red_s   = {COLOR_BITS{1'b0}};
          green_s = {COLOR_BITS{1'b0}};
          blue_s  = {COLOR_BITS{1'b0}};
        end
      endcase
    end
  end

  // Frame tracking, mode hand-over, bar counters and colour output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_vsync_r <= ~VS_ACTIVE;
      mode_pend_r  <= 3'd0;
      mode_cur     <= 3'd0;
      frame_cnt    <= 8'd0;
      scroll_off_r <= 11'd0;
      bar_px_r     <= 11'd0;
      bar_idx_r    <= 3'd0;
      red          <= {COLOR_BITS{1'b0}};
      green        <= {COLOR_BITS{1'b0}};
      blue         <= {COLOR_BITS{1'b0}};
    end else begin
      prev_vsync_r <= vsync;
      if (mode_load) begin
        mode_pend_r <= mode_sel;
      end
      // A load coinciding with the edge bypasses the pending register.
      if (frame_edge_s) begin
        frame_cnt    <= frame_cnt + 8'd1;
        scroll_off_r <= scroll_off_r + SCROLL_INC;
        mode_cur     <= mode_load ? mode_sel : mode_pend_r;
      end
      if (video_active) begin
        bar_px_r  <= nxt_px_s;
        bar_idx_r <= nxt_idx_s;
      end
      red   <= red_s;
      green <= green_s;
      blue  <= blue_s;
    end
  end

endmodule
